// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, constants and the forward S-box
package aes_pkg;

    localparam int AES_NR = 10;
    localparam int AES_NK = 4;

    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_block_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_READY
    } aes_state_e;

    // Indexed by round number; entry 0 and the tail are padding so any 4-bit counter is in range
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    // Entry 0x00 sits in the top byte
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[2047 - 8 * int'(x) -: 8];
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// aes_sub_word: four parallel forward S-box lookups on a 32-bit word
module aes_sub_word
    import aes_pkg::*;
(
    input  aes_word_t w_i,
    output aes_word_t w_o
);

    assign w_o = {sbox(w_i[31:24]), sbox(w_i[23:16]), sbox(w_i[15:8]), sbox(w_i[7:0])};

endmodule

// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative AES-128 key schedule, one round key per cycle, with a registered read port
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [127:0] key_i,
    input  logic         key_valid_i,
    output logic         key_ready_o,
    input  logic [3:0]   rk_idx_i,
    output logic [127:0] rk_o,
    output logic         keys_valid_o,
    output logic         busy_o
);

    if (NR != AES_NR) begin : g_nr_check
        $error("aes_key_expand supports only NR=10");
    end

    aes_state_e state_q;
    logic [3:0] cnt_q;
    aes_block_t store_q [NR+1];
    aes_block_t rk_q;
    aes_block_t prev;
    aes_block_t key_d;
    aes_word_t  sw;
    logic       key_ready_q;
    logic       busy_q;
    logic       valid_q;

    assign prev = store_q[cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1];

    aes_sub_word u_sub_word (
        .w_i ({prev[23:0], prev[31:24]}),
        .w_o (sw)
    );

    // Chain the four words of the next round key off the rotated, substituted last word
    always_comb begin
        aes_word_t w;
        w = sw ^ {RCON[cnt_q], 24'h0};
        key_d = '0;
        for (int i = 0; i < AES_NK; i++) begin
            w = prev[127-32*i -: 32] ^ w;
            key_d[127-32*i -: 32] = w;
        end
    end

    // Control FSM, key store writes and the registered read port
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            key_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            rk_q        <= '0;
            for (int i = 0; i <= NR; i++) store_q[i] <= '0;
        end else begin
            rk_q <= (rk_idx_i <= 4'(NR)) ? store_q[rk_idx_i] : '0;
            if (state_q == ST_EXPAND) begin
                store_q[cnt_q] <= key_d;
                cnt_q          <= cnt_q + 4'd1;
                if (cnt_q == 4'(NR)) begin
                    state_q     <= ST_READY;
                    key_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    valid_q     <= 1'b1;
                end
            end else if (key_valid_i && key_ready_q) begin
                store_q[0]  <= key_i;
                cnt_q       <= 4'd1;
                state_q     <= ST_EXPAND;
                key_ready_q <= 1'b0;
                busy_q      <= 1'b1;
                valid_q     <= 1'b0;
            end
        end
    end

    assign key_ready_o  = key_ready_q;
    assign busy_o       = busy_q;
    assign keys_valid_o = valid_q;
    assign rk_o         = rk_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: randomized and directed checks of the key expander against an algebraic AES key schedule model
module tb_aes_key_expand;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [127:0] key_i = '0;
    logic         key_valid_i = 1'b0;
    logic         key_ready_o;
    logic [3:0]   rk_idx_i = '0;
    logic [127:0] rk_o;
    logic         keys_valid_o;
    logic         busy_o;

    localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    aes_key_expand dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .key_i        (key_i),
        .key_valid_i  (key_valid_i),
        .key_ready_o  (key_ready_o),
        .rk_idx_i     (rk_idx_i),
        .rk_o         (rk_o),
        .keys_valid_o (keys_valid_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // S-box derived from GF(2^8) inversion plus the affine map
    logic [7:0] sb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [127:0] rk_of(input logic [127:0] k, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // Observable behaviour model: timestamps of the last accepted key decide status and read contents
    bit           inited = 0, have = 0, cleared = 0, rk_known = 0;
    int           ncyc = 0, acc = 0;
    logic [127:0] cur_key = '0, rk_exp = '0;
    bit           e_busy = 0, e_valid = 0;

    always @(posedge clk_i) begin : model
        bit pre_valid, pre_ready;
        pre_valid = have && (ncyc - acc >= 10);
        pre_ready = !have || pre_valid;
        ncyc++;
        if (rst_i) begin
            inited = 1; have = 0; cleared = 1; rk_known = 1; rk_exp = '0;
        end else if (inited) begin
            rk_known = (rk_idx_i > 10) || pre_valid || cleared;
            rk_exp = (rk_idx_i <= 10 && pre_valid) ? rk_of(cur_key, int'(rk_idx_i)) : '0;
            if (key_valid_i && pre_ready) begin
                cur_key = key_i; have = 1; acc = ncyc; cleared = 0;
            end
        end
        e_busy = have && (ncyc - acc < 10);
        e_valid = have && !e_busy;
    end

    always @(negedge clk_i) begin
        if (inited) begin
            check("busy", 128'(busy_o), 128'(e_busy));
            check("keys_valid", 128'(keys_valid_o), 128'(e_valid));
            check("key_ready", 128'(key_ready_o), 128'(!e_busy));
            if (rk_known) check("rk", rk_o, rk_exp);
        end
    end

    task automatic send_key(input logic [127:0] k);
        key_i = k;
        key_valid_i = 1'b1;
        @(negedge clk_i);
        key_valid_i = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int want);
        int n;
        n = 0;
        while (!keys_valid_o && n < 30) begin
            @(negedge clk_i);
            n++;
        end
        check(name, 128'(n), 128'(want));
    endtask

    task automatic rd(input string name, input int idx, input logic [127:0] exp);
        rk_idx_i = 4'(idx);
        @(negedge clk_i);
        check(name, rk_o, exp);
    endtask

    initial begin
        int nb;
        logic [127:0] k1;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = '0;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
        end
        check("model_a1_rk1", rk_of(KEY_A1, 1), 128'ha0fafe1788542cb123a339392a6c7605);
        check("model_a1_rk10", rk_of(KEY_A1, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("model_zero_rk10", rk_of('0, 10), 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        check("reset_ready", 128'(key_ready_o), 128'd1);
        check("reset_valid", 128'(keys_valid_o), 128'd0);
        check("reset_busy", 128'(busy_o), 128'd0);
        check("reset_rk", rk_o, '0);

        send_key(KEY_A1);
        wait_valid("a1_latency", 10);
        rd("a1_idx1", 1, 128'ha0fafe1788542cb123a339392a6c7605);
        rd("a1_idx10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd("a1_idx0", 0, KEY_A1);

        send_key('0);
        check("rekey_valid_drop", 128'(keys_valid_o), 128'd0);
        wait_valid("zero_latency", 10);
        rd("zero_idx1", 1, 128'h62636363626363636263636362636363);
        rd("zero_idx10", 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        send_key(KEY_A1);
        wait_valid("a1b_latency", 10);
        for (int i = 0; i < 16; i++) rd("sweep_up", i, i <= 10 ? rk_of(KEY_A1, i) : '0);
        for (int i = 10; i >= 0; i--) rd("sweep_down", i, rk_of(KEY_A1, i));

        k1 = {$urandom, $urandom, $urandom, $urandom};
        key_i = k1;
        key_valid_i = 1'b1;
        @(negedge clk_i);
        nb = 0;
        while (!key_ready_o && nb < 30) begin
            nb++;
            key_i = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk_i);
        end
        key_valid_i = 1'b0;
        check("hold_busy_cycles", 128'(nb), 128'd10);
        for (int i = 0; i <= 10; i++) rd("hold_first_key", i, rk_of(k1, i));

        send_key({$urandom, $urandom, $urandom, $urandom});
        repeat (4) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("midrst_ready", 128'(key_ready_o), 128'd1);
        check("midrst_valid", 128'(keys_valid_o), 128'd0);
        check("midrst_busy", 128'(busy_o), 128'd0);
        check("midrst_rk", rk_o, '0);
        for (int i = 0; i <= 10; i++) rd("midrst_store", i, '0);

        for (int c = 0; c < 400; c++) begin
            key_valid_i = ($urandom_range(0, 3) == 0);
            key_i = {$urandom, $urandom, $urandom, $urandom};
            rk_idx_i = 4'($urandom_range(0, 15));
            @(negedge clk_i);
        end
        key_valid_i = 1'b0;
        repeat (12) @(negedge clk_i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
